uart_text_writer: RTL and testbench

- Consumes bytes from the UART receiver and turns them into write commands for the VGA text-mode character buffer.
- Input is the receiver's byte-valid level `wr` plus its 8-bit data; output is a single-cycle character write port (address + char code).
- Tracks a cursor and interprets a small set of control codes (CR, LF, BS, FF).
- Sits between the UART receiver and the text buffer / glyph renderer.

---
 rtl/uart_text_writer.sv | 167 ++++++++++++++++
 tb/tb_uart_text_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_text_writer.sv
// UART byte stream to VGA text-buffer write port: cursor tracking plus CR/LF/BS/FF handling.
// Optional build macro UART_TEXT_LF_CR_EN makes LF also return the cursor to column 0.
module uart_text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic                      wr_i,
  input  logic [7:0]                data_i,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [7:0]                char_o,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic [$clog2(COLS)-1:0]   cur_col_o,
  output logic [$clog2(ROWS)-1:0]   cur_row_o
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] CELL_LAST = ADDR_WIDTH'(COLS * ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLEAR
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(c);
  endfunction

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == ROW_LAST) ? '0 : r + 1'b1;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  state_t             state;
  logic               wr_d;
  logic               pending;
  logic [7:0]         byte_p0;
  logic [7:0]         cmd_p1;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               byte_evt;
  logic               consume;

  assign byte_evt  = wr_i & ~wr_d;
  assign consume   = (state == IDLE) & pending;
  assign cur_col_o = col;
  assign cur_row_o = row;

  // Stage 0: rising-edge detect and one-entry hold register
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      wr_d       <= 1'b1;
      pending    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      wr_d <= wr_i;
      if (byte_evt) begin
        if (pending && !consume) overflow_o <= 1'b1;
        else                     pending    <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  // Data registers carry no reset; only their qualifiers do.
  always_ff @(posedge clk_i) begin
    if (byte_evt && (!pending || consume)) byte_p0 <= data_i;
    if (consume)                           cmd_p1  <= byte_p0;
  end

  // Stage 1: decode and registered write port
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      we_o   <= 1'b0;
      addr_o <= '0;
      char_o <= '0;
      busy_o <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) state <= EXEC;
        end

        EXEC: begin
          state <= IDLE;
          if (is_printable(cmd_p1)) begin
            we_o   <= 1'b1;
            addr_o <= cell_addr(row, col);
            char_o <= cmd_p1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= next_row(row);
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            case (cmd_p1)
              CH_CR: col <= '0;
              CH_LF: begin
                row <= next_row(row);
`ifdef UART_TEXT_LF_CR_EN
                col <= '0;
`endif
              end
              CH_BS: begin
                if (col != '0) begin
                  col    <= col - 1'b1;
                  we_o   <= 1'b1;
                  addr_o <= cell_addr(row, col - 1'b1);
                  char_o <= BLANK_CHAR;
                end
              end
              CH_FF: begin
                // First blank goes out here so the sweep covers every cell in COLS*ROWS cycles.
                state  <= CLEAR;
                col    <= '0;
                row    <= '0;
                busy_o <= 1'b1;
                we_o   <= 1'b1;
                addr_o <= '0;
                char_o <= BLANK_CHAR;
              end
              default: ;
            endcase
          end
        end

        CLEAR: begin
          if (addr_o == CELL_LAST) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            we_o   <= 1'b1;
            addr_o <= addr_o + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer: vector table for single bytes plus multi-cycle sequences.
module tb_uart_text_writer;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        wr_i;
  logic [7:0]  data_i;
  logic        we_o;
  logic [11:0] addr_o;
  logic [7:0]  char_o;
  logic        busy_o;
  logic        overflow_o;
  logic [6:0]  cur_col_o;
  logic [4:0]  cur_row_o;

  uart_text_writer #(
    .COLS(80), .ROWS(30), .ADDR_WIDTH(12), .BLANK_CHAR(8'h20)
  ) dut (
    .clk_i(clk_i), .rst(rst), .wr_i(wr_i), .data_i(data_i),
    .we_o(we_o), .addr_o(addr_o), .char_o(char_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .cur_col_o(cur_col_o), .cur_row_o(cur_row_o)
  );

  always #20 clk_i = ~clk_i;

`ifdef UART_TEXT_LF_CR_EN
  localparam int LF_COL = 0;
`else
  localparam int LF_COL = 3;
`endif

  typedef struct {
    logic [7:0] data;
    int         we;
    int         addr;
    logic [7:0] chr;
    int         col;
    int         row;
  } vec_t;

  typedef struct {
    int addr;
    int chr;
  } wr_t;

  wr_t  wlog[$];
  wr_t  mon_w;
  int   busy_cnt;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[15];

  always @(negedge clk_i) begin
    if (we_o) begin
      mon_w.addr = int'(addr_o);
      mon_w.chr  = int'(char_o);
      wlog.push_back(mon_w);
    end
    if (busy_o) busy_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst  = 1'b0;
    wr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b1;
    wlog.delete();
    busy_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    wr_i   = 1'b1;
    data_i = b;
    repeat (2) @(posedge clk_i);
    #1 wr_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n0;
    int addr_err;
    int waited;

    vecs[0]  = '{8'h42, 1, 1,   8'h42, 2,      0};
    vecs[1]  = '{8'h0D, 0, 0,   8'h00, 0,      0};
    vecs[2]  = '{8'h0A, 0, 0,   8'h00, 0,      1};
    vecs[3]  = '{8'h63, 1, 80,  8'h63, 1,      1};
    vecs[4]  = '{8'h08, 1, 80,  8'h20, 0,      1};
    vecs[5]  = '{8'h08, 0, 0,   8'h00, 0,      1};
    vecs[6]  = '{8'h01, 0, 0,   8'h00, 0,      1};
    vecs[7]  = '{8'h7F, 0, 0,   8'h00, 0,      1};
    vecs[8]  = '{8'h7E, 1, 80,  8'h7E, 1,      1};
    vecs[9]  = '{8'h20, 1, 81,  8'h20, 2,      1};
    vecs[10] = '{8'h1F, 0, 0,   8'h00, 2,      1};
    vecs[11] = '{8'h31, 1, 82,  8'h31, 3,      1};
    vecs[12] = '{8'h0A, 0, 0,   8'h00, LF_COL, 2};
    vecs[13] = '{8'h0D, 0, 0,   8'h00, 0,      2};
    vecs[14] = '{8'h39, 1, 160, 8'h39, 1,      2};

    // Reset with wr_i held high; release must not look like a new byte.
    busy_cnt = 0;
    rst    = 1'b0;
    wr_i   = 1'b1;
    data_i = 8'h55;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_we",   int'(we_o),       0);
    chk("rst_addr", int'(addr_o),     0);
    chk("rst_char", int'(char_o),     0);
    chk("rst_busy", int'(busy_o),     0);
    chk("rst_ovf",  int'(overflow_o), 0);
    chk("rst_col",  int'(cur_col_o),  0);
    chk("rst_row",  int'(cur_row_o),  0);
    rst = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("held_wr_no_write", wlog.size(), 0);
    wr_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // 'A' held for 1000 cycles: one write, three edges after the rise.
    @(posedge clk_i); #1;
    wr_i   = 1'b1;
    data_i = 8'h41;
    @(posedge clk_i); #1 chk("lat_e1_we", int'(we_o), 0);
    @(posedge clk_i); #1 chk("lat_e2_we", int'(we_o), 0);
    @(posedge clk_i); #1;
    chk("lat_e3_we",   int'(we_o),   1);
    chk("lat_e3_addr", int'(addr_o), 0);
    chk("lat_e3_char", int'(char_o), 8'h41);
    @(posedge clk_i); #1 chk("lat_e4_we", int'(we_o), 0);
    repeat (996) @(posedge clk_i);
    #1 wr_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("hold_one_write", wlog.size(), 1);
    chk("hold_col",       int'(cur_col_o), 1);

    // Single-byte vector table, continuing from col=1 row=0.
    for (int i = 0; i < 15; i++) begin
      n0 = wlog.size();
      send_byte(vecs[i].data);
      chk($sformatf("v%0d_nwr", i), wlog.size() - n0, vecs[i].we);
      if (vecs[i].we != 0 && wlog.size() > n0) begin
        chk($sformatf("v%0d_addr", i), wlog[wlog.size()-1].addr, vecs[i].addr);
        chk($sformatf("v%0d_char", i), wlog[wlog.size()-1].chr,  int'(vecs[i].chr));
      end
      chk($sformatf("v%0d_col", i), int'(cur_col_o), vecs[i].col);
      chk($sformatf("v%0d_row", i), int'(cur_row_o), vecs[i].row);
    end
    chk("table_ovf", int'(overflow_o), 0);

    // 80 printable bytes wrap to row 1; 'Z' lands at address 80.
    do_reset();
    for (int i = 0; i < 80; i++) send_byte(8'h30 + 8'(i % 10));
    send_byte(8'h5A);
    chk("wrap_nwr", wlog.size(), 81);
    if (wlog.size() == 81) begin
      chk("wrap_79_addr", wlog[79].addr, 79);
      chk("wrap_79_char", wlog[79].chr,  8'h39);
      chk("wrap_z_addr",  wlog[80].addr, 80);
      chk("wrap_z_char",  wlog[80].chr,  8'h5A);
    end
    chk("wrap_col", int'(cur_col_o), 1);
    chk("wrap_row", int'(cur_row_o), 1);

    // Bottom row: CR LF wraps the row to 0.
    do_reset();
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h78);
    chk("r29_first_addr", (wlog.size() > 0) ? wlog[0].addr : -1, 2320);
    chk("r29_col", int'(cur_col_o), 5);
    chk("r29_row", int'(cur_row_o), 29);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h78);
    chk("r29_nwr",    wlog.size(), 6);
    chk("r29_x_addr", (wlog.size() > 0) ? wlog[wlog.size()-1].addr : -1, 0);
    chk("r29_col2",   int'(cur_col_o), 1);
    chk("r29_row2",   int'(cur_row_o), 0);

    // LF at column 7.
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(8'h61);
    send_byte(8'h0A);
`ifdef UART_TEXT_LF_CR_EN
    chk("lf7_col", int'(cur_col_o), 0);
`else
    chk("lf7_col", int'(cur_col_o), 7);
`endif
    chk("lf7_row", int'(cur_row_o), 1);

    // Clear screen with two bytes arriving during the sweep.
    do_reset();
    send_byte(8'h0C);
    chk("ff_busy_mid", int'(busy_o), 1);
    chk("ff_col", int'(cur_col_o), 0);
    send_byte(8'h4B);
    chk("ff_ovf_pre", int'(overflow_o), 0);
    send_byte(8'h4C);
    chk("ff_ovf_post", int'(overflow_o), 1);
    waited = 0;
    while (busy_o && waited < 3000) begin
      @(posedge clk_i); #1;
      waited++;
    end
    chk("ff_busy_ends", int'(busy_o), 0);
    repeat (6) @(posedge clk_i);
    #1;
    chk("ff_busy_cycles", busy_cnt, 2400);
    chk("ff_nwr", wlog.size(), 2401);
    addr_err = 0;
    for (int i = 0; i < 2400 && i < wlog.size(); i++)
      if (wlog[i].addr != i || wlog[i].chr != 8'h20) addr_err++;
    chk("ff_sweep_cells_bad", addr_err, 0);
    if (wlog.size() > 2400) begin
      chk("ff_k_addr", wlog[2400].addr, 0);
      chk("ff_k_char", wlog[2400].chr,  8'h4B);
    end
    chk("ff_col_after", int'(cur_col_o), 1);
    chk("ff_row_after", int'(cur_row_o), 0);
    chk("ff_ovf_sticky", int'(overflow_o), 1);

    // Reset in the middle of a sweep aborts it and clears overflow.
    send_byte(8'h0C);
    repeat (100) @(posedge clk_i);
    #1 chk("abort_busy_pre", int'(busy_o), 1);
    rst = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_busy", int'(busy_o),     0);
    chk("abort_we",   int'(we_o),       0);
    chk("abort_ovf",  int'(overflow_o), 0);
    rst = 1'b1;
    n0 = wlog.size();
    repeat (10) @(posedge clk_i);
    #1 chk("abort_no_writes", wlog.size() - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
